// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding
// and the default requester count and register width.
package shared_reg_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/shared_reg.sv
// W-bit storage register with a load enable; cleared asynchronously by reset.
module shared_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving N requesters write access to one shared W-bit
// register; each write takes IDLE -> GRANT -> ACK, one clock per busy state.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic [1:0]     owner,
    output logic           valid,
    output logic           busy
);

    state_t       r_state;
    logic [1:0]   r_ptr;
    logic [1:0]   r_g;
    logic [1:0]   r_owner;
    logic         r_valid;
    logic [N-1:0] r_ack;

    logic [1:0]   w_pick;
    logic [W-1:0] w_sel;
    logic         w_load;

    // Scan from the highest offset down so the nearest set bit above ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_pick = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_g == 2'(i)) begin
                w_sel = wdata[i*W +: W];
            end
        end
    end

    assign w_load = (r_state == GRANT);

    shared_reg #(
        .W(W)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .i_load(w_load),
        .i_d   (w_sel),
        .o_q   (q)
    );

    // ack rises on entry to ACK and falls on leaving it, so it is one-hot for one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
            r_ack   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_g     <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_owner <= r_g;
                    r_valid <= 1'b1;
                    r_ack   <= N'(1) << r_g;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack   <= '0;
                    r_ptr   <= r_g + 2'd1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack   = r_ack;
    assign owner = r_owner;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);

endmodule
